// File: rtl/mem_pkg.sv
// Shared constants and types for the memory-structures library storage elements.
`timescale 1ns/1ps
package mem_pkg;

  localparam int DEFAULT_WIDTH = 1;

  localparam bit RST_BIT_ZERO = 1'b0;
  localparam bit RST_BIT_ONE  = 1'b1;

  localparam logic [DEFAULT_WIDTH-1:0] RST_VAL_ZERO = '0;
  localparam logic [DEFAULT_WIDTH-1:0] RST_VAL_ONES = '1;

  typedef logic [DEFAULT_WIDTH-1:0] latch_data_t;

endpackage

// File: rtl/d_latch_bit.sv
// Single-bit gated SR latch with a dominant asynchronous reset/preset.
`timescale 1ns/1ps
module d_latch_bit
  import mem_pkg::*;
#(
  parameter bit RST_BIT = RST_BIT_ZERO
) (
  input  logic clk,
  input  logic re,
  input  logic d,
  output logic q
);

  logic set_req;
  logic clr_req;

  // Gate stage: D is steered onto set or clear only while the enable is high.
  assign set_req = clk & d;
  assign clr_req = clk & ~d;

  // Storage stage: reset dominates, otherwise set/clear, otherwise hold.
  always_latch begin
    if (!re) begin
      q <= RST_BIT;
    end else if (set_req) begin
      q <= 1'b1;
    end else if (clr_req) begin
      q <= 1'b0;
    end
  end

endmodule

// File: rtl/d_latch_arst.sv
// Transparent-high D latch, WIDTH independent bits sharing enable and active-low reset.
`timescale 1ns/1ps
module d_latch_arst
  import mem_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             Re,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < 1) begin : g_bad_width
    $error("d_latch_arst: WIDTH must be at least 1");
  end

  // Each bit picks the reset-to-0 or preset-to-1 flavour from RST_VAL.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    d_latch_bit #(
      .RST_BIT (RST_VAL[i])
    ) u_bit (
      .clk (clk),
      .re  (Re),
      .d   (D[i]),
      .q   (Q[i])
    );
  end

endmodule

// File: tb/tb_d_latch_arst.sv
// Directed and randomized checks of d_latch_arst at WIDTH=1 and WIDTH=8 preset A5.
`timescale 1ns/1ps
module tb_d_latch_arst;

  localparam logic [7:0] PRESET8 = 8'hA5;

  logic       clk;
  logic       re;
  logic [0:0] d1;
  logic [0:0] q1;
  logic [7:0] d8;
  logic [7:0] q8;

  int checks = 0;
  int errors = 0;

  // Reference state: what each output must be, derived from the priority rules.
  logic [0:0] exp1;
  logic [7:0] exp8;

  d_latch_arst #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) u_dut1 (
    .clk (clk),
    .Re  (re),
    .D   (d1),
    .Q   (q1)
  );

  d_latch_arst #(
    .WIDTH   (8),
    .RST_VAL (PRESET8)
  ) u_dut8 (
    .clk (clk),
    .Re  (re),
    .D   (d8),
    .Q   (q8)
  );

  task automatic model_update();
    if (!re) begin
      exp1 = 1'b0;
      exp8 = PRESET8;
    end else if (clk) begin
      exp1 = d1;
      exp8 = d8;
    end
  endtask

  task automatic set_clk(input logic v);
    clk = v;
    model_update();
  endtask

  task automatic set_re(input logic v);
    re = v;
    model_update();
  endtask

  task automatic set_d(input logic [0:0] v1, input logic [7:0] v8);
    d1 = v1;
    d8 = v8;
    model_update();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_both(input string tag);
    check({tag, "_w1"}, {7'd0, q1}, {7'd0, exp1});
    check({tag, "_w8"}, q8, exp8);
  endtask

  initial begin
    clk  = 1'b0;
    re   = 1'b0;
    d1   = 1'b1;
    d8   = 8'hFF;
    exp1 = 1'b0;
    exp8 = PRESET8;
    model_update();

    // Reset held with D=1, clk=0
    #1;  check("rst_q0_a", {7'd0, q1}, 8'h00);
    check("rst_preset", q8, 8'hA5);
    #24; check_both("rst_mid");
    #25; check_both("rst_end");

    set_re(1'b1);
    set_clk(1'b1);
    #1;  check("rst_release", {7'd0, q1}, 8'h01);
    check_both("rst_release_m");

    // Hold: close, then change D
    set_clk(1'b0);
    #1;  set_d(1'b0, 8'h00);
    #1;  check("hold_start", {7'd0, q1}, 8'h01);
    #24; check_both("hold_mid");
    #25; check_both("hold_end");
    set_clk(1'b1);
    #1;  check("hold_reopen", {7'd0, q1}, 8'h00);

    // Glitch capture near the falling edge
    #4;  set_d(1'b1, 8'h5A);
    #10; set_clk(1'b0);
    #1;  check("glitch_cap", {7'd0, q1}, 8'h01);
    check("glitch_cap8", q8, 8'h5A);
    #14; check_both("glitch_hold_a");
    #15; check_both("glitch_hold_b");
    #25; set_clk(1'b1);
    #1;  check("glitch_reopen", {7'd0, q1}, 8'h01);

    // Transparency
    set_d(1'b0, 8'h0F);
    #0;  check("transp_zero_lat", {7'd0, q1}, 8'h00);
    #1;  check_both("transp_d0_a");
    #49; check_both("transp_d0_b");
    set_d(1'b1, 8'hF0);
    #1;  check("transp_d1", {7'd0, q1}, 8'h01);
    #49; check_both("transp_d1_b");

    // Reset override while transparent
    set_re(1'b0);
    #1;  check("ovr_hi_pulse", {7'd0, q1}, 8'h00);
    check("ovr_hi_pulse8", q8, 8'hA5);
    #4;  set_re(1'b1);
    #1;  check("ovr_hi_after", {7'd0, q1}, 8'h01);
    check("ovr_hi_after8", q8, 8'hF0);

    // Reset override while opaque
    set_clk(1'b0);
    #1;  set_re(1'b0);
    #1;  check("ovr_lo_pulse", {7'd0, q1}, 8'h00);
    #4;  set_re(1'b1);
    #1;  check("ovr_lo_after", {7'd0, q1}, 8'h00);
    check("ovr_lo_after8", q8, 8'hA5);
    #20; check_both("ovr_lo_wait");
    set_clk(1'b1);
    #1;  check("ovr_lo_reopen", {7'd0, q1}, 8'h01);

    // Width / preset on the 8-bit instance
    set_re(1'b0);
    #1;  check("w8_preset", q8, 8'hA5);
    set_re(1'b1);
    set_d(1'b0, 8'h3C);
    #1;  check("w8_load", q8, 8'h3C);
    set_clk(1'b0);
    #1;  set_d(1'b1, 8'hFF);
    #1;  check("w8_hold", q8, 8'h3C);

    // Randomized: one input changes per step so edges never coincide with D
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       set_clk(~clk);
        1:       set_re(($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1);
        default: set_d(1'($urandom), 8'($urandom));
      endcase
      #($urandom_range(1, 5));
      check_both("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
